// File: rtl/prbs_checker.sv
// Self-synchronising PRBS7/15/23/31 checker with lock tracking and a saturating error counter.
// Optional macro PRBS_CHK_BITCNT_EN adds bit_count (bits checked while locked) for BER measurement.
module prbs_checker #(
   parameter int unsigned PRBS_ORDER    = 7,
   parameter int unsigned DW            = 1,
   parameter int unsigned LOCK_COUNT    = 64,
   parameter int unsigned UNLOCK_BEATS  = 4,
   parameter int unsigned ERR_CNT_WIDTH = 16
) (
   input  logic                       clk_x8,
   input  logic                       rst,
   input  logic [DW-1:0]              d_in,
   input  logic                       d_in_valid,
   input  logic                       err_clr,
   output logic                       locked,
   output logic                       err_pulse,
   output logic [ERR_CNT_WIDTH-1:0]   err_count
`ifdef PRBS_CHK_BITCNT_EN
   ,
   output logic [ERR_CNT_WIDTH+8-1:0] bit_count
`endif
);

   localparam int unsigned TAP_B  = (PRBS_ORDER == 7)  ? 6  :
                                    (PRBS_ORDER == 15) ? 14 :
                                    (PRBS_ORDER == 23) ? 18 : 28;
   localparam int unsigned SEED_W = $clog2(PRBS_ORDER + 1);
   localparam int unsigned HUNT_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned UNL_W  = $clog2(UNLOCK_BEATS + 1);
   localparam int unsigned POP_W  = $clog2(DW + 1);
   localparam int unsigned SUM_W  = ((ERR_CNT_WIDTH > POP_W) ? ERR_CNT_WIDTH : POP_W) + 1;

   typedef enum logic [1:0] {S_SEED, S_HUNT, S_LOCKED} state_t;

   state_t                  state;
   state_t                  mode;
   logic [PRBS_ORDER-1:0]   hist;
   logic [PRBS_ORDER-1:0]   hist_n;
   logic [SEED_W-1:0]       seed_cnt;
   logic [SEED_W-1:0]       seed_n;
   logic [HUNT_W-1:0]       hunt_cnt;
   logic [HUNT_W-1:0]       hunt_n;
   logic [UNL_W-1:0]        unl_cnt;
   logic                    lock_hit;
   logic [DW-1:0]           err_bits;
   logic                    pred;
   logic                    bit_err;
   logic                    beat_err;
   logic [POP_W-1:0]        pop;
   logic [SUM_W-1:0]        err_sum;
   logic [ERR_CNT_WIDTH-1:0] err_next;

   // Walk the beat bit by bit in arrival order; SEED may hand over to HUNT mid-beat.
   always_comb begin
      hist_n   = hist;
      seed_n   = seed_cnt;
      hunt_n   = hunt_cnt;
      mode     = state;
      lock_hit = 1'b0;
      err_bits = '0;
      pred     = 1'b0;
      bit_err  = 1'b0;
      for (int i = 0; i < DW; i++) begin
         pred    = hist_n[PRBS_ORDER-1] ^ hist_n[TAP_B-1];
         bit_err = pred ^ d_in[i];
         if (mode == S_SEED) begin
            seed_n = seed_n + SEED_W'(1);
            if (seed_n == SEED_W'(PRBS_ORDER)) mode = S_HUNT;
         end else if (mode == S_HUNT) begin
            if (bit_err) hunt_n = '0;
            else if (hunt_n != HUNT_W'(LOCK_COUNT)) hunt_n = hunt_n + HUNT_W'(1);
            if (hunt_n == HUNT_W'(LOCK_COUNT)) lock_hit = 1'b1;
         end else begin
            err_bits[i] = bit_err;
         end
         hist_n = {hist_n[PRBS_ORDER-2:0], d_in[i]};
      end
   end

   assign beat_err = |err_bits;

   // Popcount of errored bits, saturating add into the error counter.
   always_comb begin
      pop = '0;
      for (int i = 0; i < DW; i++) pop = pop + POP_W'(err_bits[i]);
      err_sum  = SUM_W'(err_count) + SUM_W'(pop);
      err_next = (err_sum[SUM_W-1:ERR_CNT_WIDTH] != '0) ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk_x8) begin
      if (rst) begin
         state     <= S_SEED;
         hist      <= '0;
         seed_cnt  <= '0;
         hunt_cnt  <= '0;
         unl_cnt   <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (err_clr) err_count <= '0;
         else if (d_in_valid && state == S_LOCKED) err_count <= err_next;

         if (d_in_valid) begin
            hist <= hist_n;
            if (state == S_LOCKED) begin
               err_pulse <= beat_err;
               if (!beat_err) begin
                  unl_cnt <= '0;
               end else if (unl_cnt == UNL_W'(UNLOCK_BEATS - 1)) begin
                  state    <= S_SEED;
                  locked   <= 1'b0;
                  seed_cnt <= '0;
                  hunt_cnt <= '0;
                  unl_cnt  <= '0;
               end else begin
                  unl_cnt <= unl_cnt + UNL_W'(1);
               end
            end else if (lock_hit) begin
               state    <= S_LOCKED;
               locked   <= 1'b1;
               hunt_cnt <= '0;
               unl_cnt  <= '0;
            end else begin
               state    <= mode;
               seed_cnt <= seed_n;
               hunt_cnt <= hunt_n;
            end
         end
      end
   end

`ifdef PRBS_CHK_BITCNT_EN
   localparam int unsigned BC_W = ERR_CNT_WIDTH + 8;
   logic [BC_W:0] bc_sum;

   assign bc_sum = {1'b0, bit_count} + (BC_W + 1)'(DW);

   // Bits checked while locked, saturating; shares the clear-wins rule with err_count.
   always_ff @(posedge clk_x8) begin
      if (rst) bit_count <= '0;
      else if (err_clr) bit_count <= '0;
      else if (d_in_valid && state == S_LOCKED) bit_count <= bc_sum[BC_W] ? '1 : bc_sum[BC_W-1:0];
   end
`endif

endmodule
